// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter: rotating-priority selection among N requesters, grant held
// until the winner drops its request or the MAX_HOLD timeout preempts it.
module rr_grant_arbiter #(
  parameter int unsigned N        = 8,
  parameter int unsigned IDX_W    = 3,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             preempt
);

  localparam int unsigned HoldW = $clog2(MAX_HOLD) + 1;
  localparam bit          HoldEn = (MAX_HOLD != 0);
  localparam logic [HoldW-1:0] HoldLast = HoldW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             preempt_q, preempt_d;
  logic             arb;
  logic             win_req;
  logic             timeout;
  logic [IDX_W-1:0] sel;

  // First set bit of mask, searching upward from start and wrapping mod N.
  function automatic logic [IDX_W-1:0] sel_idx(input logic [N-1:0] mask,
                                               input logic [IDX_W-1:0] start);
    logic [IDX_W-1:0] idx;
    logic             found;
    sel_idx = '0;
    found   = 1'b0;
    for (int unsigned o = 0; o < N; o++) begin
      idx = start + IDX_W'(o);
      if (!found && mask[idx]) begin
        sel_idx = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign win_req = req[idx_q];
  assign timeout = HoldEn && (hold_q == HoldLast);

  // Next-state: hold, release or timeout, then re-arbitrate from the (possibly advanced) ptr.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;
    arb       = 1'b0;
    sel       = '0;
    unique case (state_q)
      StIdle: begin
        if (en && |req) arb = 1'b1;
      end
      StGrant: begin
        if (win_req && !timeout) begin
          // Saturate rather than wrap when there is no timeout.
          if (hold_q != '1) hold_d = hold_q + 1'b1;
        end else begin
          // Winner is searched last because ptr moves just past it.
          ptr_d     = idx_q + 1'b1;
          preempt_d = win_req;
          if (en && |req) begin
            arb = 1'b1;
          end else begin
            state_d = StIdle;
            grant_d = '0;
            idx_d   = '0;
            hold_d  = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (arb) begin
      sel     = sel_idx(req, ptr_d);
      state_d = StGrant;
      idx_d   = sel;
      grant_d = {{(N-1){1'b0}}, 1'b1} << sel;
      hold_d  = '0;
    end
  end

  // State registers; async reset returns everything, including ptr, to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      idx_q     <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = idx_q;
  assign grant_valid = |grant_q;
  assign preempt     = preempt_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter: cycle-by-cycle vector table plus hand sequences
// for timeout preemption and asynchronous reset.
module tb_rr_grant_arbiter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       preempt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       en;
    logic [7:0] req;
    logic       exp_valid;
    logic [2:0] exp_idx;
    logic       exp_pre;
  } vec_t;

  vec_t vecs[$];

  rr_grant_arbiter #(
    .N       (8),
    .IDX_W   (3),
    .MAX_HOLD(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .req        (req),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid),
    .preempt    (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic e, input logic [7:0] r, input logic v, input logic [2:0] i,
                     input logic p);
    vec_t x;
    x.en = e; x.req = r; x.exp_valid = v; x.exp_idx = i; x.exp_pre = p;
    vecs.push_back(x);
  endtask

  task automatic chk_grant(input string tag, input logic v, input logic [2:0] i, input logic p);
    logic [7:0] oh;
    oh = v ? (8'h01 << i) : 8'h00;
    chk({tag, " grant"}, 32'(grant), 32'(oh));
    chk({tag, " valid"}, 32'(grant_valid), 32'(v));
    chk({tag, " preempt"}, 32'(preempt), 32'(p));
    if (v) chk({tag, " idx"}, 32'(grant_idx), 32'(i));
  endtask

  initial begin
    logic [7:0] m;

    // Rotation: each cycle the current winner j drops req, next one wins.
    for (int j = 0; j < 8; j++) begin
      m = 8'h01 << j;
      add(1'b1, ~m, 1'b1, 3'(j + 1), 1'b0);
    end
    // Walk on to winner 5 (ptr lands at 6 on release).
    for (int j = 0; j < 5; j++) begin
      m = 8'h01 << j;
      add(1'b1, ~m, 1'b1, 3'(j + 1), 1'b0);
    end
    // Wrap/skip from ptr=6.
    add(1'b1, 8'h05, 1'b1, 3'd0, 1'b0);
    add(1'b1, 8'h04, 1'b1, 3'd2, 1'b0);
    add(1'b1, 8'h01, 1'b1, 3'd0, 1'b0);
    add(1'b1, 8'h00, 1'b0, 3'd0, 1'b0);
    // Back-to-back handover, ptr=1.
    add(1'b1, 8'h06, 1'b1, 3'd1, 1'b0);
    add(1'b1, 8'h04, 1'b1, 3'd2, 1'b0);
    add(1'b1, 8'h00, 1'b0, 3'd0, 1'b0);
    // en gating, ptr=3.
    add(1'b1, 8'h10, 1'b1, 3'd4, 1'b0);
    add(1'b0, 8'h10, 1'b1, 3'd4, 1'b0);
    add(1'b0, 8'h80, 1'b0, 3'd0, 1'b0);
    add(1'b0, 8'h80, 1'b0, 3'd0, 1'b0);
    add(1'b0, 8'h80, 1'b0, 3'd0, 1'b0);
    add(1'b1, 8'h80, 1'b1, 3'd7, 1'b0);
    add(1'b1, 8'h00, 1'b0, 3'd0, 1'b0);

    // Reset with all requests high.
    rst_n = 1'b0;
    en    = 1'b1;
    req   = 8'hFF;
    repeat (3) step();
    chk_grant("reset", 1'b0, 3'd0, 1'b0);
    chk("reset idx", 32'(grant_idx), 32'd0);
    rst_n = 1'b1;
    step();
    chk_grant("first", 1'b1, 3'd0, 1'b0);

    foreach (vecs[k]) begin
      en  = vecs[k].en;
      req = vecs[k].req;
      step();
      chk_grant($sformatf("vec%0d", k), vecs[k].exp_valid, vecs[k].exp_idx, vecs[k].exp_pre);
    end

    // Timeout: idx 0 held 16 cycles, then preempted in favour of idx 3.
    en  = 1'b1;
    req = 8'h09;
    step();
    chk_grant("to start", 1'b1, 3'd0, 1'b0);
    for (int c = 1; c < 16; c++) begin
      step();
      chk_grant($sformatf("to hold%0d", c), 1'b1, 3'd0, 1'b0);
    end
    step();
    chk_grant("to switch", 1'b1, 3'd3, 1'b1);

    // Lone requester is re-granted with a preempt pulse every 16 cycles.
    req = 8'h08;
    for (int r = 0; r < 2; r++) begin
      for (int c = 1; c < 16; c++) begin
        step();
        chk_grant($sformatf("solo%0d hold%0d", r, c), 1'b1, 3'd3, 1'b0);
      end
      step();
      chk_grant($sformatf("solo%0d regrant", r), 1'b1, 3'd3, 1'b1);
    end
    step();
    chk_grant("solo pulse end", 1'b1, 3'd3, 1'b0);

    // Async reset mid-grant drops outputs without a clock edge.
    rst_n = 1'b0;
    #2;
    chk_grant("async rst", 1'b0, 3'd0, 1'b0);
    chk("async rst idx", 32'(grant_idx), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk_grant("post rst", 1'b1, 3'd3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
